// File: rtl/sys_pll_pkg.sv
// rtl/sys_pll_pkg.sv - state encoding, counter sizing and default timing for the PLL reset sequencer
package sys_pll_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } seq_state_t;

  localparam int DEF_RST_HOLD_CYCLES     = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 100000;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_SYNC_STAGES         = 2;

  // Width able to hold (largest cycle count - 1); never narrower than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sys_pll_reset_sequencer_if.sv
// rtl/sys_pll_reset_sequencer_if.sv - PLL lock/control and status bundle of the reset sequencer
interface sys_pll_reset_sequencer_if;

  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       fail;
  logic [2:0] state_o;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  modport master (
    input  pll_locked, soft_reset_req,
    output pll_rst, sys_reset_n, fail, state_o, retry_cnt, lock_loss_cnt
  );

  modport slave (
    output pll_locked, soft_reset_req,
    input  pll_rst, sys_reset_n, fail, state_o, retry_cnt, lock_loss_cnt
  );

endinterface

// File: rtl/sys_pll_reset_sequencer_sync_bit.sv
// rtl/sys_pll_reset_sequencer_sync_bit.sv - STAGES-deep single-bit synchronizer with async clear
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/sys_pll_reset_sequencer.sv
// rtl/sys_pll_reset_sequencer.sv - holds the PLL in reset, qualifies lock, releases and monitors system reset
module sys_pll_reset_sequencer
  import sys_pll_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES
) (
  input logic                       clk,
  input logic                       reset_n,
  sys_pll_reset_sequencer_if.master bus
);

  localparam int CW = cnt_width(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] C_HOLD_LD = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] C_STB_LD  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_TMO_LD  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    C_MAX_RETRY = 2'(MAX_RETRIES);

  seq_state_t    r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_ld;
  logic [1:0]    r_retry, w_retry, w_retry_inc;
  logic [7:0]    r_loss, w_loss, w_loss_inc;
  logic          r_pll_rst, r_sys_reset_n, r_fail;
  logic          w_lock_s, w_cnt_zero, w_enter;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .i_d   (bus.pll_locked),
    .o_q   (w_lock_s)
  );

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_retry_inc = r_retry + 2'd1;
  assign w_loss_inc  = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;
  // A soft request re-enters RESET_PLL even from RESET_PLL, so the hold time restarts.
  assign w_enter     = (w_next != r_state) || bus.soft_reset_req;

  always_comb begin
    w_next  = r_state;
    w_retry = r_retry;
    w_loss  = r_loss;
    if (bus.soft_reset_req) begin
      w_next  = ST_RESET_PLL;
      w_retry = '0;
    end else begin
      case (r_state)
        ST_RESET_PLL: if (w_cnt_zero) w_next = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_next = ST_STABLE;
          end else if (w_cnt_zero) begin
            w_retry = w_retry_inc;
            w_next  = (w_retry_inc == C_MAX_RETRY) ? ST_FAIL : ST_RESET_PLL;
          end
        end
        ST_STABLE: begin
          if (!w_lock_s) begin
            w_loss = w_loss_inc;
            w_next = ST_WAIT_LOCK;
          end else if (w_cnt_zero) begin
            w_retry = '0;
            w_next  = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!w_lock_s) begin
            w_loss = w_loss_inc;
            w_next = ST_RESET_PLL;
          end
        end
        ST_FAIL: w_next = ST_FAIL;
        default: w_next = ST_RESET_PLL;
      endcase
    end
  end

  always_comb begin
    w_cnt_ld = '0;
    case (w_next)
      ST_RESET_PLL: w_cnt_ld = C_HOLD_LD;
      ST_WAIT_LOCK: w_cnt_ld = C_TMO_LD;
      ST_STABLE:    w_cnt_ld = C_STB_LD;
      default:      w_cnt_ld = '0;
    endcase
  end

  // Reset is treated as entry into RESET_PLL, so the hold window also follows reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_RESET_PLL;
      r_cnt         <= C_HOLD_LD;
      r_retry       <= '0;
      r_loss        <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cnt         <= w_enter ? w_cnt_ld : (w_cnt_zero ? r_cnt : r_cnt - CW'(1));
      r_retry       <= w_retry;
      r_loss        <= w_loss;
      r_pll_rst     <= (w_next == ST_RESET_PLL) || (w_next == ST_FAIL);
      r_sys_reset_n <= (w_next == ST_RUN);
      r_fail        <= (w_next == ST_FAIL);
    end
  end

  assign bus.pll_rst       = r_pll_rst;
  assign bus.sys_reset_n   = r_sys_reset_n;
  assign bus.fail          = r_fail;
  assign bus.state_o       = r_state;
  assign bus.retry_cnt     = r_retry;
  assign bus.lock_loss_cnt = r_loss;

endmodule
